mdu_e: RTL and testbench

- E-stage multiply/divide unit. Consumes the operands (RSE/RTE after forwarding) and the decoded MD operation of the instruction held in the ID/EX pipeline register.
- Owns the architectural HI/LO registers and models multi-cycle latency with a busy countdown.
- The hazard unit stalls D-stage MD-class instructions while `start | busy`.
- md_out feeds the E-stage result mux for MFHI/MFLO.

---
 rtl/mdu_e.sv | 124 ++++++++++++
 tb/tb_mdu_e.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: owns HI/LO and models MD latency with a busy countdown.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (md_op 9-12); otherwise those codes act as no-ops.
module mdu_e #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   load;
    logic [63:0]        pend;
    logic [63:0]        res;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               is_mult;
    logic               is_div;
    logic               accept;

    assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'b0, rs} * {32'b0, rt};

    // Start-class decode and acceptance
    always_comb begin
        is_mult = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mult = is_mult || (md_op == OP_MADD) || (md_op == OP_MADDU)
                          || (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`endif
        is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
        accept  = start && !busy && (is_mult || is_div);
        load    = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end

    // Result computed at start; divide by zero keeps the current HI/LO
    always_comb begin
        res = {hi, lo};
        case (md_op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV: begin
                if (rt != 32'b0) begin
                    if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF)
                        res = {32'h0, 32'h8000_0000};
                    else
                        res = {32'($signed(rs) % $signed(rt)), 32'($signed(rs) / $signed(rt))};
                end
            end
            OP_DIVU: begin
                if (rt != 32'b0)
                    res = {rs % rt, rs / rt};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  res = {hi, lo} + prod_s;
            OP_MADDU: res = {hi, lo} + prod_u;
            OP_MSUB:  res = {hi, lo} - prod_s;
            OP_MSUBU: res = {hi, lo} - prod_u;
`endif
            default:  res = {hi, lo};
        endcase
    end

    always_comb begin
        md_out = 32'b0;
        if (md_op == OP_MFHI)
            md_out = hi;
        else if (md_op == OP_MFLO)
            md_out = lo;
    end

    // Countdown, commit on 1->0, and MTHI/MTLO only when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= 32'b0;
            lo   <= 32'b0;
            busy <= 1'b0;
            cnt  <= '0;
            pend <= 64'b0;
        end else if (accept) begin
            pend <= res;
            cnt  <= load;
            busy <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                hi   <= pend[63:32];
                lo   <= pend[31:0];
                busy <= 1'b0;
            end
        end else if (md_op == OP_MTHI) begin
            hi <= rs;
        end else if (md_op == OP_MTLO) begin
            lo <= rs;
        end
    end

endmodule

// File: tb/tb_mdu_e.sv
// Randomized self-checking bench for mdu_e against an arithmetic HI/LO reference model.
module tb_mdu_e;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs     (rs),
        .rt     (rt),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of a start-class op on the model; returns expected busy length
    function automatic int model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, acc;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        acc = {m_hi, m_lo};
        case (op)
            4'd1: begin {m_hi, m_lo} = sa * sb; return MC; end
            4'd2: begin {m_hi, m_lo} = ua * ub; return MC; end
            4'd3: begin
                if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
                return DC;
            end
            4'd4: begin
                if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
                return DC;
            end
`ifdef MDU_MADD_EN
            4'd9:  begin {m_hi, m_lo} = acc + 64'(sa * sb); return MC; end
            4'd10: begin {m_hi, m_lo} = acc + ua * ub;      return MC; end
            4'd11: begin {m_hi, m_lo} = acc - 64'(sa * sb); return MC; end
            4'd12: begin {m_hi, m_lo} = acc - ua * ub;      return MC; end
`endif
            default: return 0;
        endcase
    endfunction

    // inject: 0 none, 1 MTLO while busy, 2 second start pulse while busy
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int inject);
        logic [31:0] old_hi, old_lo;
        int          n_exp, n_busy;
        old_hi = m_hi;
        old_lo = m_lo;
        n_exp  = model(op, a, b);
        start = 1'b1; md_op = op; rs = a; rt = b;
        tick;
        start = 1'b0; md_op = 4'd0; rs = $urandom; rt = $urandom;
        n_busy = 0;
        while (busy === 1'b1 && n_busy < 50) begin
            check("hold_hi", hi, old_hi);
            check("hold_lo", lo, old_lo);
            n_busy++;
            if (inject == 1 && n_busy == 2) begin
                md_op = 4'd8; rs = 32'hDEAD_BEEF;
            end else if (inject == 2 && n_busy == 2) begin
                start = 1'b1; md_op = 4'd1; rs = $urandom; rt = $urandom;
            end else begin
                start = 1'b0; md_op = 4'd0;
            end
            tick;
        end
        check("busy_cycles", 32'(n_busy), 32'(n_exp));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("busy_low", 32'(busy), 32'd0);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] val);
        md_op = op; rs = val;
        tick;
        md_op = 4'd0;
        if (op == 4'd7) m_hi = val;
        else            m_lo = val;
    endtask

    task automatic mfcheck;
        md_op = 4'd5; #1; check("mfhi", md_out, m_hi);
        md_op = 4'd6; #1; check("mflo", md_out, m_lo);
        md_op = 4'd0; #1; check("md_out_idle", md_out, 32'd0);
    endtask

    initial begin
        logic [3:0]  ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
        logic [3:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; start = 1'b0; md_op = 4'd0; rs = 32'd0; rt = 32'd0;
        tick;
        tick;
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (3) begin
            tick;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_hi", hi, 32'd0);
            check("rst_lo", lo, 32'd0);
        end
        md_op = 4'd5; #1;
        check("rst_mfhi", md_out, 32'd0);
        md_op = 4'd0;

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(4'd4, 32'd7, 32'd0, 0);
        check("divz_hi", hi, 32'hFFFF_FFFF);
        check("divz_lo", lo, 32'hFFFF_FFFD);

        mt(4'd7, 32'h1234_5678);
        mfcheck();

        run_op(4'd4, 32'd100, 32'd7, 1);
        check("mtlo_busy_lo", lo, 32'd14);
        check("mtlo_busy_hi", hi, 32'd2);

        run_op(4'd1, 32'd1000, 32'hFFFF_FFF6, 2);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        // Reset during the third busy cycle of a MULTU
        start = 1'b1; md_op = 4'd2; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
        tick;
        start = 1'b0; md_op = 4'd0;
        tick;
        tick;
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        repeat (8) tick;
        check("nocommit_hi", hi, 32'd0);
        check("nocommit_lo", lo, 32'd0);
        check("nocommit_busy", 32'(busy), 32'd0);

        mt(4'd7, 32'd0);
        mt(4'd8, 32'hFFFF_FFFF);
        run_op(4'd10, 32'd1, 32'd1, 0);
`ifdef MDU_MADD_EN
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
`else
        check("maddu_off_hi", hi, 32'd0);
        check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 10)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) b = {28'd0, b[3:0]};
            if (op == 4'd7 || op == 4'd8) mt(op, a);
            else                          run_op(op, a, b, int'($urandom_range(0, 2)));
            mfcheck();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
